// File: rtl/rx_sample_dpll.sv
// rx_sample_dpll: oversampling bit-sampling DPLL for the UTMI receive path.
// Macro RX_DPLL_SYNC_EN adds a 2-flop synchroniser on rx_d.
module rx_sample_dpll #(
   parameter int OSR        = 4,
   parameter int CNT_W      = 4,
   parameter int SAMPLE_PH  = 1,
   parameter int TOL        = 1,
   parameter int LOCK_EDGES = 8,
   parameter int MAX_RUN    = 7
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             en,
   input  logic             mode,
   input  logic             rx_d,
   input  logic             clr_slip,
   output logic             sample,
   output logic             rx_bit,
   output logic [CNT_W-1:0] phase,
   output logic             locked,
   output logic [7:0]       slip_cnt
);

   localparam logic [CNT_W-1:0] PH_LAST = CNT_W'(OSR - 1);
   localparam logic [CNT_W-1:0] PH_HALF = CNT_W'(OSR / 2);
   localparam logic [CNT_W-1:0] PH_WRAP = CNT_W'(OSR - 2);
   localparam logic [CNT_W-1:0] PH_SMP  = CNT_W'(SAMPLE_PH);
   localparam logic [7:0]       LK_MAX  = 8'(LOCK_EDGES);
   localparam logic [7:0]       RUN_MAX = 8'(MAX_RUN);

   logic             rx_s;
   logic             rx_p;
   logic             det;
   logic             in_win;
   logic             held;
   logic             held_nx;
   logic             cap;
   logic [CNT_W-1:0] phase_nx;
   logic [7:0]       lk_cnt;
   logic [7:0]       lk_inc;
   logic [7:0]       run;

`ifdef RX_DPLL_SYNC_EN
   logic [1:0] sync;

   // Two-flop synchroniser on the raw line input
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) sync <= '0;
      else      sync <= {sync[0], rx_d};
   end

   assign rx_s = sync[1];
`else
   assign rx_s = rx_d;
`endif

   assign det    = rx_s ^ rx_p;
   assign in_win = (int'(phase) >= OSR - 1 - TOL) ||
                   (int'(phase) <= TOL - 1);
   // held blocks a second strobe when a late nudge parks phase
   assign cap    = en && (phase == PH_SMP) && !held;
   assign lk_inc = (lk_cnt >= LK_MAX) ? lk_cnt : lk_cnt + 8'd1;

   // Next phase: hard resync, +-1 nudge, or free-run wrap
   always_comb begin
      phase_nx = phase;
      held_nx  = 1'b0;
      if (!en)
         phase_nx = '0;
      else if (det && !mode)
         phase_nx = '0;
      else if (det && (phase == PH_LAST))
         phase_nx = '0;
      else if (det && (phase < PH_HALF))
         held_nx = 1'b1;
      else if (det)
         phase_nx = (phase == PH_WRAP) ? '0 : phase + CNT_W'(2);
      else
         phase_nx = (phase == PH_LAST) ? '0 : phase + CNT_W'(1);
   end

   // Phase counter, edge history and sample strobe
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rx_p   <= 1'b0;
         phase  <= '0;
         held   <= 1'b0;
         sample <= 1'b0;
         rx_bit <= 1'b0;
      end else begin
         rx_p   <= rx_s;
         phase  <= phase_nx;
         held   <= held_nx;
         sample <= cap;
         if (cap) rx_bit <= rx_s;
      end
   end

   // Lock tracking and run-length loss detection
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         lk_cnt <= '0;
         locked <= 1'b0;
         run    <= '0;
      end else if (!en) begin
         lk_cnt <= '0;
         locked <= 1'b0;
         run    <= '0;
      end else if (det) begin
         run <= '0;
         if (in_win) begin
            lk_cnt <= lk_inc;
            if (lk_inc == LK_MAX) locked <= 1'b1;
         end else begin
            lk_cnt <= '0;
            locked <= 1'b0;
         end
      end else if (cap) begin
         if (run >= RUN_MAX) begin
            lk_cnt <= '0;
            locked <= 1'b0;
         end else begin
            run <= run + 8'd1;
         end
      end
   end

   // Saturating out-of-window edge counter
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
         slip_cnt <= '0;
      else if (clr_slip)
         slip_cnt <= '0;
      else if (en && det && !in_win && (slip_cnt != 8'hFF))
         slip_cnt <= slip_cnt + 8'd1;
   end

endmodule

// File: tb/tb_rx_sample_dpll.sv
// tb_rx_sample_dpll: directed bench for rx_sample_dpll (default build).
// Vector table for free-run/resync/nudge, hand sequences for lock and slip.
module tb_rx_sample_dpll;

   logic       CLK;
   logic       RST;
   logic       en;
   logic       mode;
   logic       rx_d;
   logic       clr_slip;
   logic       sample;
   logic       rx_bit;
   logic [3:0] phase;
   logic       locked;
   logic [7:0] slip_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       mode;
      logic       rx;
      logic [3:0] ph;
      logic       smp;
      logic       bt;
      logic [7:0] slp;
   } vec_t;

   vec_t tbl[$];

   rx_sample_dpll dut (
      .CLK      (CLK),
      .RST      (RST),
      .en       (en),
      .mode     (mode),
      .rx_d     (rx_d),
      .clr_slip (clr_slip),
      .sample   (sample),
      .rx_bit   (rx_bit),
      .phase    (phase),
      .locked   (locked),
      .slip_cnt (slip_cnt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   function automatic vec_t mk(input logic m, input logic r,
                               input logic [3:0] p, input logic s,
                               input logic b, input logic [7:0] sl);
      vec_t v;
      v.mode = m; v.rx = r; v.ph = p; v.smp = s; v.bt = b; v.slp = sl;
      return v;
   endfunction

   // Async reset asserted mid-cycle, outputs checked before any edge
   task automatic apply_reset();
      #3;
      RST = 1'b0;
      #1;
      check("rst_phase", 32'(phase), 0);
      check("rst_sample", 32'(sample), 0);
      check("rst_rx_bit", 32'(rx_bit), 0);
      check("rst_locked", 32'(locked), 0);
      check("rst_slip", 32'(slip_cnt), 0);
      en = 1'b0; mode = 1'b0; rx_d = 1'b0; clr_slip = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
      step();
   endtask

   // From phase 0: align to phase 3 and send 8 on-time edges
   task automatic lock_up();
      repeat (3) step();
      for (int i = 1; i <= 8; i++) begin
         rx_d = ~rx_d;
         step();
         check($sformatf("lock_edge%0d", i), 32'(locked), 32'(i == 8));
         if (i < 8) repeat (3) step();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      logic cv;

      tbl.push_back(mk(0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 2, 1, 0, 0));
      tbl.push_back(mk(0, 0, 3, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 2, 1, 0, 0));
      tbl.push_back(mk(0, 0, 3, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 2, 1, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 2, 1, 1, 0));
      tbl.push_back(mk(0, 1, 3, 0, 1, 0));
      tbl.push_back(mk(1, 1, 0, 0, 1, 0));
      tbl.push_back(mk(1, 1, 1, 0, 1, 0));
      tbl.push_back(mk(1, 0, 1, 1, 0, 1));
      tbl.push_back(mk(1, 0, 2, 0, 0, 1));
      tbl.push_back(mk(1, 1, 0, 0, 0, 1));
      tbl.push_back(mk(1, 1, 1, 0, 0, 1));
      tbl.push_back(mk(1, 1, 2, 1, 1, 1));
      tbl.push_back(mk(1, 1, 3, 0, 1, 1));
      tbl.push_back(mk(1, 0, 0, 0, 1, 1));
      tbl.push_back(mk(1, 0, 1, 0, 1, 1));
      tbl.push_back(mk(1, 0, 2, 1, 0, 1));

      RST = 1'b1; en = 1'b0; mode = 1'b0; rx_d = 1'b0; clr_slip = 1'b0;
      step();
      apply_reset();

      // free-run, hard resync at phase 2, nudges at phases 1, 2, 3
      en = 1'b1;
      for (int i = 0; i < tbl.size(); i++) begin
         mode = tbl[i].mode;
         rx_d = tbl[i].rx;
         step();
         check($sformatf("vec%0d", i),
               {17'd0, phase, sample, rx_bit, locked, slip_cnt},
               {17'd0, tbl[i].ph, tbl[i].smp, tbl[i].bt, 1'b0, tbl[i].slp});
      end

      // lock after 8 edges, then loss after 8 strobes without edges
      apply_reset();
      en = 1'b1;
      lock_up();
      n = 0;
      for (int c = 0; c < 40 && n < 8; c++) begin
         step();
         if (sample) begin
            n++;
            check($sformatf("run_strobe%0d", n), 32'(locked), 32'(n < 8));
         end
      end
      check("run_strobes_seen", 32'(n), 8);

      // slip from locked state, saturation, clear priority
      apply_reset();
      en = 1'b1;
      lock_up();
      step();
      rx_d = ~rx_d;
      step();
      check("slip_locked", 32'(locked), 0);
      check("slip_first", 32'(slip_cnt), 1);
      check("slip_phase", 32'(phase), 0);
      for (int i = 0; i < 299; i++) begin
         step();
         rx_d = ~rx_d;
         step();
      end
      check("slip_sat", 32'(slip_cnt), 255);
      step();
      rx_d = ~rx_d;
      clr_slip = 1'b1;
      step();
      clr_slip = 1'b0;
      check("slip_clr", 32'(slip_cnt), 0);

      // enable drop mid-bit
      apply_reset();
      en = 1'b1;
      step();
      rx_d = ~rx_d;
      step();
      check("en_pre_slip", 32'(slip_cnt), 1);
      lock_up();
      step();
      step();
      cv = rx_d;
      check("en_pre_sample", 32'(sample), 1);
      check("en_pre_bit", 32'(rx_bit), 32'(cv));
      en = 1'b0;
      step();
      check("en_off_phase", 32'(phase), 0);
      check("en_off_locked", 32'(locked), 0);
      check("en_off_bit", 32'(rx_bit), 32'(cv));
      check("en_off_slip", 32'(slip_cnt), 1);
      rx_d = ~rx_d;
      step();
      step();
      check("en_hold_bit", 32'(rx_bit), 32'(cv));
      check("en_hold_phase", 32'(phase), 0);
      en = 1'b1;
      step();
      check("en_back_phase", 32'(phase), 1);
      check("en_back_slip", 32'(slip_cnt), 1);
      step();
      check("en_back_sample", 32'(sample), 1);
      check("en_back_bit", 32'(rx_bit), 32'(rx_d));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
